// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - LC-3b 5-stage stall/flush sequencer with debug halt/step and perf counters
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [2:0]       id_src1,
    input  logic [2:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [2:0]       ex_dest,
    input  logic             ex_is_load,
    input  logic             mem_br_taken,
    input  logic             halt_req,
    input  logic             step,
    output logic             halted,
    output logic             load_pc,
    output logic             pc_redirect,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             clear_if_id,
    output logic             clear_id_ex,
    output logic             clear_ex_mem,
    output logic             clear_mem_wb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

    state_t state, state_nxt;
    logic   dstall, load_use, flush_evt, stall_evt;

    assign dstall   = dmem_req & ~dmem_resp;
    assign load_use = ex_is_load & ((id_use1 & (id_src1 == ex_dest)) |
                                    (id_use2 & (id_src2 == ex_dest)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        halted       = 1'b0;
        load_pc      = 1'b1;
        pc_redirect  = 1'b0;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        clear_if_id  = 1'b0;
        clear_id_ex  = 1'b0;
        clear_ex_mem = 1'b0;
        clear_mem_wb = 1'b0;
        flush_evt    = 1'b0;
        stall_evt    = 1'b0;

        case (state)
            RUN:     if (halt_req && !dstall) state_nxt = HALTED;
            HALTED: begin
                if (step)           state_nxt = STEP;
                else if (!halt_req) state_nxt = RUN;
            end
            STEP:    if (!dstall) state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase

        if (state == HALTED) begin
            // Full freeze: nothing moves, nothing is bubbled, branches wait.
            halted      = 1'b1;
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            stall_evt   = 1'b1;
        end else begin
            halted = (state == STEP);
            if (dstall) begin
                load_pc      = 1'b0;
                load_if_id   = 1'b0;
                load_id_ex   = 1'b0;
                load_ex_mem  = 1'b0;
                clear_mem_wb = 1'b1;
                stall_evt    = 1'b1;
            end else if (mem_br_taken) begin
                pc_redirect  = 1'b1;
                clear_if_id  = 1'b1;
                clear_id_ex  = 1'b1;
                clear_ex_mem = 1'b1;
                flush_evt    = 1'b1;
            end else if (load_use) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                clear_id_ex = 1'b1;
                stall_evt   = 1'b1;
            end else if (!imem_resp) begin
                load_pc     = 1'b0;
                clear_if_id = 1'b1;
                stall_evt   = 1'b1;
            end
        end

        // Reset drives bubbles into every stage regardless of state.
        if (!reset_n) begin
            halted       = 1'b0;
            load_pc      = 1'b0;
            pc_redirect  = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
            clear_ex_mem = 1'b1;
            clear_mem_wb = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [2:0]  id_src1, id_src2, ex_dest;
    logic        id_use1, id_use2, ex_is_load, mem_br_taken, halt_req, step;
    logic        halted, load_pc, pc_redirect;
    logic        load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
        .id_use2(id_use2), .ex_dest(ex_dest), .ex_is_load(ex_is_load),
        .mem_br_taken(mem_br_taken), .halt_req(halt_req), .step(step), .halted(halted),
        .load_pc(load_pc), .pc_redirect(pc_redirect), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex), .clear_ex_mem(clear_ex_mem),
        .clear_mem_wb(clear_mem_wb), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {halted, load_pc, pc_redirect, loads IF/ID..MEM/WB, clears IF/ID..MEM/WB}
    logic [10:0] outv;
    assign outv = {halted, load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem,
                   load_mem_wb, clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb};

    localparam logic [10:0] O_RESET = 11'b0_0_0_0000_1111;
    localparam logic [10:0] O_NORM  = 11'b0_1_0_1111_0000;
    localparam logic [10:0] O_LU    = 11'b0_0_0_0111_0100;
    localparam logic [10:0] O_IMEM  = 11'b0_0_0_1111_1000;
    localparam logic [10:0] O_BR    = 11'b0_1_1_1111_1110;
    localparam logic [10:0] O_DST   = 11'b0_0_0_0001_0001;
    localparam logic [10:0] O_HALT  = 11'b1_0_0_0000_0000;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: debug mode as an integer, counters as plain saturating ints.
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
    int m_mode, m_stall, m_flush;

    function automatic bit f_dstall();
        return dmem_req && !dmem_resp;
    endfunction

    function automatic bit f_lu();
        return ex_is_load && ((id_use1 && id_src1 == ex_dest) || (id_use2 && id_src2 == ex_dest));
    endfunction

    function automatic logic [10:0] ref_outs();
        logic [10:0] o;
        if (!reset_n) return O_RESET;
        if (m_mode == M_HALT) return O_HALT;
        if (f_dstall())          o = O_DST;
        else if (mem_br_taken)   o = O_BR;
        else if (f_lu())         o = O_LU;
        else if (!imem_resp)     o = O_IMEM;
        else                     o = O_NORM;
        o[10] = (m_mode == M_STEP);
        return o;
    endfunction

    task automatic model_advance();
        bit ds, frozen, flushed;
        ds = f_dstall();
        if (m_mode == M_HALT) begin
            frozen = 1; flushed = 0;
        end else begin
            frozen  = ds || (!mem_br_taken && (f_lu() || !imem_resp));
            flushed = !ds && mem_br_taken;
        end
        if (frozen)  m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (flushed) m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
        case (m_mode)
            M_RUN:  if (halt_req && !ds) m_mode = M_HALT;
            M_HALT: if (step) m_mode = M_STEP; else if (!halt_req) m_mode = M_RUN;
            default: if (!ds) m_mode = M_HALT;
        endcase
    endtask

    // One cycle: outputs checked mid-cycle against the model, counters after the edge.
    task automatic cyc(input string name);
        #2;
        chk({name, "_out"}, 32'(outv), 32'(ref_outs()));
        model_advance();
        @(posedge clk);
        #1;
        chk({name, "_stall"}, 32'(stall_cnt), 32'(m_stall));
        chk({name, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    endtask

    typedef struct {
        logic       imem, dreq, dresp;
        logic [2:0] s1, s2;
        logic       u1, u2;
        logic [2:0] dst;
        logic       ld, br;
        logic [10:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic imem, dreq, dresp, input logic [2:0] s1, s2,
                                input logic u1, u2, input logic [2:0] dst,
                                input logic ld, br, input logic [10:0] exp);
        vec_t v;
        v.imem = imem; v.dreq = dreq; v.dresp = dresp; v.s1 = s1; v.s2 = s2;
        v.u1 = u1; v.u2 = u2; v.dst = dst; v.ld = ld; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        imem_resp = v.imem; dmem_req = v.dreq; dmem_resp = v.dresp;
        id_src1 = v.s1; id_src2 = v.s2; id_use1 = v.u1; id_use2 = v.u2;
        ex_dest = v.dst; ex_is_load = v.ld; mem_br_taken = v.br;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_mode = M_RUN; m_stall = 0; m_flush = 0;
        #2;
        chk("reset_out", 32'(outv), 32'(O_RESET));
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        chk("reset_flush", 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t quiet, tbl[12];

    initial begin
        quiet = mk(1, 0, 0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, O_NORM);
        drive(quiet);
        halt_req = 1'b0; step = 1'b0;
        tbl[0]  = mk(1, 0, 0, 3'd1, 3'd2, 1, 1, 3'd6, 1, 0, O_NORM);
        tbl[1]  = mk(1, 0, 0, 3'd3, 3'd0, 1, 0, 3'd3, 1, 0, O_LU);
        tbl[2]  = mk(1, 0, 0, 3'd3, 3'd0, 0, 0, 3'd3, 1, 0, O_NORM);
        tbl[3]  = mk(1, 0, 0, 3'd0, 3'd5, 0, 1, 3'd5, 1, 0, O_LU);
        tbl[4]  = mk(1, 0, 0, 3'd5, 3'd5, 1, 1, 3'd5, 0, 0, O_NORM);
        tbl[5]  = mk(0, 0, 0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, O_IMEM);
        tbl[6]  = mk(0, 0, 0, 3'd2, 3'd0, 1, 0, 3'd2, 1, 0, O_LU);
        tbl[7]  = mk(1, 0, 0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 1, O_BR);
        tbl[8]  = mk(0, 0, 0, 3'd4, 3'd0, 1, 0, 3'd4, 1, 1, O_BR);
        tbl[9]  = mk(1, 1, 0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 1, O_DST);
        tbl[10] = mk(1, 1, 1, 3'd1, 3'd0, 1, 0, 3'd1, 1, 0, O_LU);
        tbl[11] = mk(0, 1, 0, 3'd1, 3'd0, 1, 0, 3'd1, 1, 1, O_DST);

        // Reset release, quiet pipeline for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) cyc("idle");
        chk("idle_stall0", 32'(stall_cnt), 32'd0);

        // Single load-use cycle, then same with id_use1 dropped.
        do_reset();
        drive(tbl[1]);
        #2 chk("lu_out", 32'(outv), 32'(O_LU));
        model_advance();
        @(posedge clk); #1;
        chk("lu_stall1", 32'(stall_cnt), 32'd1);
        drive(tbl[2]);
        #2 chk("nolu_out", 32'(outv), 32'(O_NORM));
        model_advance();
        @(posedge clk); #1;
        drive(quiet);

        // Four dstall cycles with a pending branch, then completion redirects.
        do_reset();
        drive(tbl[9]);
        for (int i = 0; i < 4; i++) begin
            #2 chk("dst_freeze", 32'(outv), 32'(O_DST));
            model_advance();
            @(posedge clk); #1;
        end
        dmem_resp = 1'b1;
        #2 chk("dst_redirect", 32'(outv), 32'(O_BR));
        model_advance();
        @(posedge clk); #1;
        chk("dst_flush1", 32'(flush_cnt), 32'd1);
        chk("dst_stall4", 32'(stall_cnt), 32'd4);
        drive(quiet);

        // Debug halt, single step, release.
        do_reset();
        halt_req = 1'b1;
        cyc("halt_enter");
        #2 chk("halt_frozen", 32'(outv), 32'(O_HALT));
        model_advance(); @(posedge clk); #1;
        step = 1'b1;
        cyc("step_req");
        step = 1'b0;
        #2 chk("step_run", 32'(outv), 32'({1'b1, O_NORM[9:0]}));
        model_advance(); @(posedge clk); #1;
        #2 chk("step_refrozen", 32'(outv), 32'(O_HALT));
        model_advance(); @(posedge clk); #1;
        halt_req = 1'b0;
        cyc("halt_release");
        #2 chk("back_run", 32'(outv), 32'(O_NORM));
        model_advance(); @(posedge clk); #1;

        // Table vectors in RUN.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            #2 chk($sformatf("tbl%0d", i), 32'(outv), 32'(tbl[i].exp));
            model_advance();
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(m_stall));
            chk($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(m_flush));
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            imem_resp    = ($urandom_range(3) != 0);
            dmem_req     = ($urandom_range(3) == 0);
            dmem_resp    = $urandom_range(1);
            id_src1      = 3'($urandom_range(3));
            id_src2      = 3'($urandom_range(3));
            id_use1      = $urandom_range(1);
            id_use2      = $urandom_range(1);
            ex_dest      = 3'($urandom_range(3));
            ex_is_load   = ($urandom_range(2) == 0);
            mem_br_taken = ($urandom_range(7) == 0);
            if ($urandom_range(24) == 0) halt_req = ~halt_req;
            step         = ($urandom_range(7) == 0);
            if (m_mode == M_HALT) dmem_req = 1'b0;
            cyc("rand");
        end
        halt_req = 1'b0; step = 1'b0;
        drive(quiet);

        // Saturate stall_cnt while halted, then reset in the middle of a stalled STEP.
        do_reset();
        halt_req = 1'b1;
        while (m_stall < 16'hFFFE) begin
            model_advance();
            @(posedge clk);
        end
        #1;
        chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) cyc("sat");
        chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
        step = 1'b1;
        cyc("sat_step");
        step = 1'b0;
        dmem_req = 1'b1; dmem_resp = 1'b0;
        #2 chk("step_dstall", 32'(outv), 32'({1'b1, O_DST[9:0]}));
        reset_n = 1'b0;
        #1;
        chk("midstep_rst_out", 32'(outv), 32'(O_RESET));
        chk("midstep_rst_stall", 32'(stall_cnt), 32'd0);
        chk("midstep_rst_flush", 32'(flush_cnt), 32'd0);
        m_mode = M_RUN; m_stall = 0; m_flush = 0;
        halt_req = 1'b0;
        drive(quiet);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
